// File: rtl/mmio_timer_pkg.sv
// Shared register map, bit positions and FSM encoding for the memory-mapped timer.
package mmio_timer_pkg;

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_PRESCALE = 3'd1;
  localparam logic [2:0] REG_COUNT    = 3'd2;
  localparam logic [2:0] REG_COMPARE  = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_EN   = 2;

  localparam int STAT_MATCH = 0;
  localparam int STAT_DONE  = 1;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUNNING = 2'd1,
    EXPIRED = 2'd2
  } timer_state_t;

endpackage

// File: rtl/mmio_timer_prescaler.sv
// Divides clk by (divisor+1) while run is high; tick marks the last cycle of each division.
module timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] divisor,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_r;

  assign tick = run & (cnt_r == divisor);

  // Divider counter: held at zero when stopped or cleared, wraps on each tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {PRESCALE_W{1'b0}};
    end else if (clear || !run || tick) begin
      cnt_r <= {PRESCALE_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Bus-responder timer: 32-byte register window, prescaled counter with compare match,
// sticky MATCH/DONE status and a level interrupt.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0100,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        Irq
);

  logic [2:0]            ctrl_r;
  logic [PRESCALE_W-1:0] prescale_r;
  logic [31:0]           count_r;
  logic [31:0]           compare_r;
  logic [1:0]            status_r;
  timer_state_t          state_r;

  logic                  hit_s;
  logic                  wr_s;
  logic [2:0]            reg_idx_s;
  logic                  wr_ctrl_s;
  logic                  wr_prescale_s;
  logic                  wr_count_s;
  logic                  wr_compare_s;
  logic                  wr_status_s;
  logic                  run_s;
  logic                  tick_s;
  logic                  tick_eff_s;
  logic                  pre_clear_s;
  logic [2:0]            ctrl_n_s;
  logic [31:0]           count_n_s;
  logic [1:0]            status_set_s;
  logic [1:0]            status_clr_s;
  logic [1:0]            status_n_s;
  timer_state_t          state_n_s;
  logic [31:0]           rdata_s;
  logic                  unused_s;

  assign hit_s         = (DataAdr[31:5] == BASE_ADDR[31:5]);
  assign wr_s          = MemWrite & hit_s;
  assign reg_idx_s     = DataAdr[4:2];
  assign wr_ctrl_s     = wr_s & (reg_idx_s == REG_CTRL);
  assign wr_prescale_s = wr_s & (reg_idx_s == REG_PRESCALE);
  assign wr_count_s    = wr_s & (reg_idx_s == REG_COUNT);
  assign wr_compare_s  = wr_s & (reg_idx_s == REG_COMPARE);
  assign wr_status_s   = wr_s & (reg_idx_s == REG_STATUS);
  assign run_s         = (state_r == RUNNING);
  // A bus write to COUNT on a tick edge swallows that tick entirely.
  assign tick_eff_s    = tick_s & ~wr_count_s;
  assign unused_s      = ^DataAdr[1:0];

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .clear   (pre_clear_s),
    .run     (run_s),
    .divisor (prescale_r),
    .tick    (tick_s)
  );

  // Next-state for control, count, status and FSM; bus writes override tick effects.
  always_comb begin
    ctrl_n_s     = ctrl_r;
    count_n_s    = count_r;
    state_n_s    = state_r;
    status_set_s = 2'b00;
    pre_clear_s  = 1'b0;

    if (tick_eff_s) begin
      if (count_r == compare_r) begin
        status_set_s[STAT_MATCH] = 1'b1;
        if (ctrl_r[CTRL_PERIODIC]) begin
          count_n_s = 32'd0;
        end else begin
          status_set_s[STAT_DONE] = 1'b1;
          ctrl_n_s[CTRL_EN]       = 1'b0;
          state_n_s               = EXPIRED;
        end
      end else begin
        count_n_s = count_r + 32'd1;
      end
    end else begin
      count_n_s = count_r;
    end

    if (wr_count_s) begin
      count_n_s = WriteData;
    end else begin
      status_set_s = status_set_s;
    end

    if (wr_ctrl_s) begin
      ctrl_n_s = WriteData[2:0];
      if (!WriteData[CTRL_EN]) begin
        state_n_s   = STOPPED;
        pre_clear_s = 1'b1;
      end else if (state_r != RUNNING) begin
        state_n_s   = RUNNING;
        pre_clear_s = 1'b1;
      end else begin
        state_n_s = RUNNING;
      end
    end else begin
      pre_clear_s = 1'b0;
    end

    if (wr_status_s) begin
      status_clr_s = WriteData[1:0];
    end else begin
      status_clr_s = 2'b00;
    end
    // Set beats a simultaneous write-1-to-clear.
    status_n_s = (status_r & ~status_clr_s) | status_set_s;
  end

  // Register state update.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_r     <= 3'd0;
      prescale_r <= {PRESCALE_W{1'b0}};
      count_r    <= 32'd0;
      compare_r  <= 32'hFFFF_FFFF;
      status_r   <= 2'b00;
      state_r    <= STOPPED;
    end else begin
      ctrl_r   <= ctrl_n_s;
      count_r  <= count_n_s;
      status_r <= status_n_s;
      state_r  <= state_n_s;
      if (wr_prescale_s) begin
        prescale_r <= WriteData[PRESCALE_W-1:0];
      end
      if (wr_compare_s) begin
        compare_r <= WriteData;
      end
    end
  end

  // Zero-latency read mux; reserved slots and misses return zero.
  always_comb begin
    rdata_s = 32'd0;
    if (hit_s) begin
      case (reg_idx_s)
        REG_CTRL:     rdata_s = {29'd0, ctrl_r};
        REG_PRESCALE: rdata_s = 32'(prescale_r);
        REG_COUNT:    rdata_s = count_r;
        REG_COMPARE:  rdata_s = compare_r;
        REG_STATUS:   rdata_s = {30'd0, status_r};
        default:      rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  assign ReadData = rdata_s;
  assign Hit      = hit_s;
  assign Irq      = status_r[STAT_MATCH] & ctrl_r[CTRL_IRQ_EN];

endmodule

// File: tb/tb_mmio_timer.sv
// Directed-vector bench for mmio_timer: reset, periodic, one-shot, W1C, collision, reset mid-run.
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_PRE  = BASE + 32'h04;
  localparam logic [31:0] A_CNT  = BASE + 32'h08;
  localparam logic [31:0] A_CMP  = BASE + 32'h0C;
  localparam logic [31:0] A_STAT = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Hit;
  logic        Irq;

  int n_vec = 0;
  int n_err = 0;

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Hit       (Hit),
    .Irq       (Irq)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    MemWrite = 1'b0;
    DataAdr  = a;
    #1;
    d = ReadData;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1; MemWrite = 1'b0; DataAdr = 32'd0; WriteData = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    rd(A_CMP, d);
    n_vec++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL reset_compare got %h exp ffffffff", d); end
    n_vec++; if (Hit !== 1'b1) begin n_err++; $display("FAIL reset_hit got %b exp 1", Hit); end
    rd(A_CTRL, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_ctrl got %h exp 0", d); end
    n_vec++; if (Irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %b exp 0", Irq); end
    rd(A_CNT, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_count got %h exp 0", d); end
    rd(32'h0000_0060, d);
    n_vec++; if (Hit !== 1'b0) begin n_err++; $display("FAIL miss_hit got %b exp 0", Hit); end
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL miss_rdata got %h exp 0", d); end
    wr(32'h0000_0008, 32'h0000_1234);
    wr(BASE + 32'h14, 32'hDEAD_BEEF);
    rd(A_CNT, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL outside_write got %h exp 0", d); end
    rd(BASE + 32'h14, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reserved_read got %h exp 0", d); end
  endtask

  task automatic test_periodic();
    logic [31:0] d;
    logic [31:0] exp;
    wr(A_PRE, 32'd0);
    wr(A_CMP, 32'd3);
    wr(A_CTRL, 32'h7);
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      rd(A_CNT, d);
      exp = 32'(i % 4);
      n_vec++; if (d !== exp) begin n_err++; $display("FAIL periodic_count E%0d got %h exp %h", i, d, exp); end
      rd(A_STAT, d);
      exp = (i >= 4) ? 32'd1 : 32'd0;
      n_vec++; if (d !== exp) begin n_err++; $display("FAIL periodic_status E%0d got %h exp %h", i, d, exp); end
      n_vec++; if (Irq !== exp[0]) begin n_err++; $display("FAIL periodic_irq E%0d got %b exp %b", i, Irq, exp[0]); end
    end
    wr(A_CTRL, 32'h4);
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    n_vec++; if (Irq !== 1'b1) begin n_err++; $display("FAIL w1c_pre_irq got %b exp 1", Irq); end
    wr(A_STAT, 32'h1);
    rd(A_STAT, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL w1c_clear got %h exp 0", d); end
    n_vec++; if (Irq !== 1'b0) begin n_err++; $display("FAIL w1c_irq got %b exp 0", Irq); end
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'h7);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    wr(A_STAT, 32'h1);
    rd(A_STAT, d);
    n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL w1c_set_wins got %h exp 1", d); end
    n_vec++; if (Irq !== 1'b1) begin n_err++; $display("FAIL w1c_set_irq got %b exp 1", Irq); end
    rd(A_CNT, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL w1c_match_count got %h exp 0", d); end
    wr(A_CTRL, 32'h0);
    wr(A_STAT, 32'h3);
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic [31:0] exp;
    wr(A_CNT, 32'd0);
    wr(A_PRE, 32'd2);
    wr(A_CMP, 32'd1);
    wr(A_CTRL, 32'h1);
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      rd(A_CNT, d);
      exp = (i >= 3) ? 32'd1 : 32'd0;
      n_vec++; if (d !== exp) begin n_err++; $display("FAIL oneshot_count E%0d got %h exp %h", i, d, exp); end
      rd(A_STAT, d);
      exp = (i == 6) ? 32'd3 : 32'd0;
      n_vec++; if (d !== exp) begin n_err++; $display("FAIL oneshot_status E%0d got %h exp %h", i, d, exp); end
    end
    rd(A_CTRL, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL oneshot_ctrl got %h exp 0", d); end
    n_vec++; if (Irq !== 1'b0) begin n_err++; $display("FAIL oneshot_irq got %b exp 0", Irq); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      rd(A_CNT, d);
      n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL oneshot_frozen C%0d got %h exp 1", i, d); end
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    wr(A_STAT, 32'h3);
    wr(A_PRE, 32'd0);
    wr(A_CMP, 32'd2);
    wr(A_CNT, 32'd0);
    wr(A_CTRL, 32'h1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd(A_CNT, d);
    n_vec++; if (d !== 32'd2) begin n_err++; $display("FAIL collide_pre got %h exp 2", d); end
    wr(A_CNT, 32'h10);
    rd(A_CNT, d);
    n_vec++; if (d !== 32'h10) begin n_err++; $display("FAIL collide_write got %h exp 10", d); end
    rd(A_STAT, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL collide_nomatch got %h exp 0", d); end
    @(posedge clk); #1;
    rd(A_CNT, d);
    n_vec++; if (d !== 32'h11) begin n_err++; $display("FAIL collide_next got %h exp 11", d); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d;
    wr(A_CTRL, 32'h7);
    wr(A_CNT, 32'd5);
    rd(A_CNT, d);
    n_vec++; if (d !== 32'd5) begin n_err++; $display("FAIL midrst_setup got %h exp 5", d); end
    @(negedge clk);
    reset     = 1'b1;
    MemWrite  = 1'b1;
    DataAdr   = A_CNT;
    WriteData = 32'h55;
    @(posedge clk); #1;
    reset    = 1'b0;
    MemWrite = 1'b0;
    rd(A_CNT, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL midrst_count got %h exp 0", d); end
    rd(A_CTRL, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL midrst_ctrl got %h exp 0", d); end
    rd(A_PRE, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL midrst_prescale got %h exp 0", d); end
    rd(A_CMP, d);
    n_vec++; if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL midrst_compare got %h exp ffffffff", d); end
    n_vec++; if (Irq !== 1'b0) begin n_err++; $display("FAIL midrst_irq got %b exp 0", Irq); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      rd(A_CNT, d);
      n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL midrst_hold C%0d got %h exp 0", i, d); end
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_w1c();
    test_oneshot();
    test_collision();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
Memory-mapped timer peripheral that acts as a bus responder on the processor's data-memory interface (DataAdr, WriteData, MemWrite, ReadData), in parallel with the data memory. It decodes a 32-byte window and exposes control, prescale, count, compare and status registers. It counts prescaled clock ticks and raises a sticky match flag and an interrupt line. The top level muxes ReadData between memory and this block using Hit.

Parameters:
BASE_ADDR, 32'h0000_0100, byte base of the register window; must be 32-byte aligned.
PRESCALE_W, 16, width of the prescale divisor field.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
MemWrite  input  1  write strobe from the processor
DataAdr  input  32  byte address from the processor
WriteData  input  32  store data from the processor
ReadData  output  32  register read data; combinational; 0 when not Hit
Hit  output  1  combinational; 1 when DataAdr[31:5] == BASE_ADDR[31:5]
Irq  output  1  STATUS.MATCH & CTRL.IRQ_EN

Behaviour:
- One clock, clk. Reset is synchronous and active-high. Reset dominates any same-cycle bus write.
- Register index is DataAdr[4:2]. DataAdr[1:0] is ignored, and only full-word access is supported.
- Writes take effect at the rising edge when MemWrite & Hit. Reads are combinational, with zero latency.
- Register map:
  - 0x00 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN; other bits read 0.
  - 0x04 PRESCALE: [PRESCALE_W-1:0]; other bits read 0.
  - 0x08 COUNT: R/W, 32 bits.
  - 0x0C COMPARE: R/W, 32 bits.
  - 0x10 STATUS: bit0 MATCH (sticky, write-1-to-clear), bit1 DONE (sticky, W1C).
  - 0x14-0x1C: read 0; writes ignored.
- Reset values: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, prescale counter=0, state STOPPED, Irq=0. ReadData is 0 unless Hit.
- FSM states:
  - STOPPED:
    - Writing CTRL with EN=1 moves to RUNNING at that same edge.
    - The prescale counter is held at 0.
  - RUNNING:
    - The prescale counter increments each cycle.
    - When it equals PRESCALE, a tick occurs and the counter returns to 0.
    - On a tick with COUNT==COMPARE:
      - MATCH is set.
      - If PERIODIC: COUNT<=0; stay in RUNNING.
      - Else: DONE is set, EN cleared, COUNT holds, move to EXPIRED.
    - On a tick otherwise: COUNT<=COUNT+1, wrapping 32'hFFFF_FFFF->0.
    - The period is (COMPARE+1)*(PRESCALE+1) cycles.
  - EXPIRED:
    - Idle with COUNT frozen.
    - Writing CTRL with EN=1 moves to RUNNING and clears the prescale counter.
  - Writing CTRL with EN=0 in any state moves to STOPPED and clears the prescale counter. COUNT holds.
- Simultaneous events:
  - Bus write to COUNT on a tick edge: the written value wins, the tick is discarded, and MATCH is not set.
  - Bus write to COMPARE on a tick edge: the comparison uses the old COMPARE.
  - Bus write to PRESCALE mid-count: takes effect from the next cycle's comparison.
  - STATUS W1C on the same edge as a MATCH/DONE set: set wins.
  - Writes outside the window are ignored.

Decomposition:
- Package mmio_timer_pkg holds:
  - register offset localparams (REG_CTRL..REG_STATUS);
  - CTRL and STATUS bit indices;
  - typedef enum logic [1:0] {STOPPED, RUNNING, EXPIRED} timer_state_t.
- Sub-module timer_prescaler:
  - inputs clk, reset, clear, run, divisor;
  - output tick.

Test Plan:
- Reset, then read BASE+0x0C -> ReadData=32'hFFFF_FFFF and Hit=1. Read CTRL -> 0, Irq=0. DataAdr=0x60 -> Hit=0 and ReadData=0.
- Periodic run: PRESCALE=0, COMPARE=3, write CTRL=0x7 at edge E0.
  - COUNT is 1,2,3 after E1..E3.
  - At E4, MATCH=1, Irq=1 and COUNT=0.
  - The next match occurs at E8.
- One-shot run: PRESCALE=2, COMPARE=1, write CTRL=0x1 at E0.
  - COUNT=1 after E3.
  - At E6, MATCH=1 and DONE=1, and CTRL reads 0.
  - COUNT stays at 1 for 10 more cycles.
- W1C: with MATCH=1, write STATUS=0x1 -> MATCH=0 and Irq=0. Repeat with the write on a match edge -> MATCH remains 1.
- Collision: write COUNT=0x10 on a tick edge (PRESCALE=0, running) -> COUNT reads 0x10 the next cycle, and 0x11 one cycle later.
- Reset mid-run: assert reset during RUNNING with COUNT=5 -> next cycle all registers are at reset values, Irq=0 and COUNT stays 0.
